// File: rtl/ntt_pkg.sv
// Shared types and defaults for the NTT stage sequencer.
package ntt_pkg;

   localparam int unsigned LOG_N_DEF          = 12;
   localparam int unsigned LOG_CORE_COUNT_DEF = 5;

   typedef logic [3:0] stage_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_OUT   = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   // Beats per stage: N / (4 * core count)
   function automatic int unsigned beats(input int unsigned log_n, input int unsigned log_core);
      return 32'd1 << (log_n - log_core - 2);
   endfunction

endpackage

// File: rtl/ntt_stage_sequencer_beat_counter.sv
// Hold-aware beat counter; restart reloads zero and may issue beat 0 in the same cycle.
module ntt_beat_counter #(
   parameter int unsigned BEATS  = 32,
   parameter int unsigned BEAT_W = $clog2(BEATS) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic              en,
   output logic [BEAT_W-1:0] beat_c,
   output logic              last_c
);

   logic [BEAT_W-1:0] count;

   assign beat_c = restart ? '0 : count;
   assign last_c = (beat_c == BEAT_W'(BEATS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (restart || en) begin
         count <= beat_c + BEAT_W'(en);
      end
   end

endmodule

// File: rtl/ntt_stage_sequencer.sv
// NTT stage sequencer: walks LOG_N butterfly stages with drain gaps, then a readout pass.
// Optional NTT_INVERSE_EN adds an inverse input selecting Gentleman-Sande stage order.
module ntt_stage_sequencer
   import ntt_pkg::*;
#(
   parameter int unsigned LOG_N          = LOG_N_DEF,
   parameter int unsigned LOG_CORE_COUNT = LOG_CORE_COUNT_DEF,
   parameter int unsigned ADDR_W         = 9,
   parameter int unsigned PIPE_LAT       = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              hold,
`ifdef NTT_INVERSE_EN
   input  logic              inverse,
`endif
   output logic              busy,
   output logic              done,
   output logic              router_valid,
   output logic              out_mode,
   output logic [3:0]        log_m,
   output logic [3:0]        log_t,
   output logic [ADDR_W-1:0] address_0,
   output logic [ADDR_W-1:0] address_1
);

   localparam int unsigned BEATS   = beats(LOG_N, LOG_CORE_COUNT);
   localparam int unsigned BEAT_W  = $clog2(BEATS) + 1;
   localparam int unsigned DRAIN_W = $clog2(PIPE_LAT + 1);

   seq_state_t         state, state_n, pass_c;
   stage_t             stage, stage_n;
   logic [DRAIN_W-1:0] drain_cnt, drain_cnt_n;
   logic               enter_c, issue_c, last_c, inv_c;
   logic [BEAT_W-1:0]  beat_c;
   logic [3:0]         log_m_c, log_t_c;
   logic [ADDR_W-1:0]  base_c;

`ifdef NTT_INVERSE_EN
   logic inverse_q;
   assign inv_c = (state == ST_IDLE) ? inverse : inverse_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inverse_q <= 1'b0;
      end else if (state == ST_IDLE && enter_c) begin
         inverse_q <= inverse;
      end
   end
`else
   assign inv_c = 1'b0;
`endif

   ntt_beat_counter #(
      .BEATS  (BEATS),
      .BEAT_W (BEAT_W)
   ) u_beat_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (enter_c),
      .en      (issue_c),
      .beat_c  (beat_c),
      .last_c  (last_c)
   );

   // Target pass state; entering a pass issues beat 0 on the same edge unless held
   always_comb begin
      pass_c      = state;
      stage_n     = stage;
      drain_cnt_n = '0;
      enter_c     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !done) begin
               pass_c  = ST_RUN;
               stage_n = '0;
               enter_c = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt == DRAIN_W'(PIPE_LAT)) begin
               stage_n = stage_t'(stage + 4'd1);
               pass_c  = (stage_n == stage_t'(LOG_N)) ? ST_OUT : ST_RUN;
               enter_c = 1'b1;
            end else begin
               drain_cnt_n = drain_cnt + DRAIN_W'(1);
            end
         end
         ST_DONE: pass_c = ST_IDLE;
         default: ;
      endcase
   end

   // Beat issue and pass exit
   always_comb begin
      issue_c = !hold && (pass_c == ST_RUN || pass_c == ST_OUT);
      state_n = pass_c;
      if (issue_c && last_c) begin
         state_n = (pass_c == ST_OUT) ? ST_DONE : ST_DRAIN;
      end
   end

   // Stage configuration and ping-pong addressing for the beat being issued
   always_comb begin
      if (pass_c == ST_OUT) begin
         log_m_c = 4'(LOG_N - 1);
         log_t_c = 4'd0;
      end else if (inv_c) begin
         log_m_c = 4'(LOG_N - 1 - 32'(stage_n));
         log_t_c = 4'(stage_n);
      end else begin
         log_m_c = 4'(stage_n);
         log_t_c = 4'(LOG_N - 1 - 32'(stage_n));
      end
      base_c = stage_n[0] ? ADDR_W'(2 * BEATS) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         stage        <= '0;
         drain_cnt    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         router_valid <= 1'b0;
         out_mode     <= 1'b0;
         log_m        <= '0;
         log_t        <= '0;
         address_0    <= '0;
         address_1    <= '0;
      end else begin
         state        <= state_n;
         stage        <= stage_n;
         drain_cnt    <= drain_cnt_n;
         busy         <= (state_n != ST_IDLE);
         done         <= (state == ST_DONE);
         router_valid <= issue_c;
         out_mode     <= (state_n == ST_OUT) || (state == ST_OUT);
         if (issue_c) begin
            log_m     <= log_m_c;
            log_t     <= log_t_c;
            address_0 <= base_c + ADDR_W'(beat_c);
            address_1 <= base_c + ADDR_W'(BEATS) + ADDR_W'(beat_c);
         end
      end
   end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Randomized bench for ntt_stage_sequencer against a queue of expected beats.
module tb_ntt_stage_sequencer;

   localparam int unsigned LOG_N          = 12;
   localparam int unsigned LOG_CORE_COUNT = 5;
   localparam int unsigned ADDR_W         = 9;
   localparam int unsigned PIPE_LAT       = 6;
   localparam int unsigned BEATS          = 1 << (LOG_N - LOG_CORE_COUNT - 2);
   localparam int unsigned LATENCY        = LOG_N * (BEATS + PIPE_LAT) + BEATS;
   localparam int unsigned TOTAL          = (LOG_N + 1) * BEATS;
   localparam int unsigned BW             = 1 + 4 + 4 + 2 * ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              hold;
   logic              inverse;
   logic              busy, done, router_valid, out_mode;
   logic [3:0]        log_m, log_t;
   logic [ADDR_W-1:0] address_0, address_1;

   int n_cmp = 0;
   int n_err = 0;

   logic [BW-1:0] exp_q[$];

   always #5 clk = ~clk;

   ntt_stage_sequencer #(
      .LOG_N          (LOG_N),
      .LOG_CORE_COUNT (LOG_CORE_COUNT),
      .ADDR_W         (ADDR_W),
      .PIPE_LAT       (PIPE_LAT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .hold         (hold),
`ifdef NTT_INVERSE_EN
      .inverse      (inverse),
`endif
      .busy         (busy),
      .done         (done),
      .router_valid (router_valid),
      .out_mode     (out_mode),
      .log_m        (log_m),
      .log_t        (log_t),
      .address_0    (address_0),
      .address_1    (address_1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [BW-1:0] observed();
      return {out_mode, log_m, log_t, address_0, address_1};
   endfunction

   // Expected beat list: LOG_N stages alternating regions, then one readout pass
   task automatic build_model(input bit inv);
      int unsigned lm, lt, base;
      exp_q.delete();
      for (int unsigned s = 0; s < LOG_N; s++) begin
         lm   = inv ? (LOG_N - 1 - s) : s;
         lt   = inv ? s : (LOG_N - 1 - s);
         base = (s % 2) * 2 * BEATS;
         for (int unsigned b = 0; b < BEATS; b++)
            exp_q.push_back({1'b0, 4'(lm), 4'(lt), ADDR_W'(base + b), ADDR_W'(base + BEATS + b)});
      end
      base = (LOG_N % 2) * 2 * BEATS;
      for (int unsigned b = 0; b < BEATS; b++)
         exp_q.push_back({1'b1, 4'(LOG_N - 1), 4'd0, ADDR_W'(base + b), ADDR_W'(base + BEATS + b)});
   endtask

   task automatic run_xform(input int hold_pct, input bit noisy, input bit inv, input int abort_at);
      int  cyc, idx, gap, busy_bad, done_seen;
      bit  finished;
      build_model(inv);
      @(negedge clk);
      start   = 1'b1;
      inverse = inv;
      hold    = (int'($urandom_range(99)) < hold_pct);
      cyc = 0; idx = 0; gap = 0; busy_bad = 0; finished = 1'b0;
      while (!finished) begin
         @(negedge clk);
         cyc++;
         start = noisy && ($urandom_range(99) < 5);
         hold  = (int'($urandom_range(99)) < hold_pct);
         if (router_valid) begin
            if (idx > 0 && idx % BEATS == 0) begin
               if (hold_pct == 0) check("drain_gap", gap, PIPE_LAT);
               else               check("drain_gap_min", gap >= PIPE_LAT, 1);
            end
            if (idx == 0 && !inv && hold_pct == 0)
               check("first_beat", {log_m, log_t, address_0, address_1},
                     {4'd0, 4'(LOG_N - 1), ADDR_W'(0), ADDR_W'(BEATS)});
            if (idx == 0 && inv && hold_pct == 0)
               check("inv_first", {log_m, log_t}, {4'(LOG_N - 1), 4'd0});
            if (exp_q.size() == 0) check("extra_beat", 1, 0);
            else                   check($sformatf("beat%0d", idx), observed(), exp_q.pop_front());
            idx++;
            gap = 0;
            if (abort_at >= 0 && idx == abort_at * int'(BEATS) + 3) begin
               rst_n = 1'b0;
               #1;
               check("abort_outputs",
                     {busy, done, router_valid, out_mode, log_m, log_t, address_0, address_1}, 0);
               start = 1'b0;
               hold  = 1'b0;
               done_seen = 0;
               repeat (4) begin
                  @(negedge clk);
                  if (done || busy) done_seen++;
               end
               rst_n = 1'b1;
               repeat (3) begin
                  @(negedge clk);
                  if (done || busy || router_valid) done_seen++;
               end
               check("abort_quiet", done_seen, 0);
               return;
            end
         end else begin
            gap++;
         end
         if (done) begin
            if (hold_pct == 0) check("latency", cyc - 1, LATENCY);
            check("beat_count", idx, TOTAL);
            check("busy_at_done", busy, 0);
            if (noisy) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("done_pulse", done, 0);
            repeat (3) @(negedge clk);
            check("idle_after_done", {busy, router_valid, out_mode}, 0);
            finished = 1'b1;
         end else if (!busy) begin
            busy_bad++;
         end
         if (!finished && cyc > 4000) begin
            check("timeout", 1, 0);
            finished = 1'b1;
         end
      end
      check("busy_held", busy_bad, 0);
      start = 1'b0;
      hold  = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      hold    = 1'b0;
      inverse = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {busy, done, router_valid, out_mode, log_m, log_t, address_0, address_1}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_quiet", {busy, router_valid}, 0);

      run_xform(0, 1'b0, 1'b0, -1);
      run_xform(30, 1'b0, 1'b0, -1);
      run_xform(0, 1'b1, 1'b0, -1);
      run_xform(20, 1'b1, 1'b0, 5);
      run_xform(0, 1'b0, 1'b0, -1);
`ifdef NTT_INVERSE_EN
      run_xform(0, 1'b0, 1'b1, -1);
      run_xform(30, 1'b1, 1'b1, -1);
      run_xform(0, 1'b0, 1'b0, -1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
